// File: rtl/roi_box_ctrl_pkg.sv
// Shared definitions for the ROI box controller: geometry width, mode encoding,
// default limits and the saturating step helpers used by the shadow datapath.
package roi_pkg;

    localparam int GEO_W = 10;
    typedef logic [GEO_W-1:0] geo_t;

    typedef enum logic [1:0] {
        MODE_OFF  = 2'd0,
        MODE_MOVE = 2'd1,
        MODE_SIZE = 2'd2
    } mode_e;

    localparam geo_t H_LIM  = 10'd1023;
    localparam geo_t V_LIM  = 10'd719;
    localparam geo_t STEP   = 10'd4;
    localparam geo_t W_MIN  = 10'd8;
    localparam geo_t H_MIN  = 10'd8;
    localparam geo_t X_INIT = 10'd110;
    localparam geo_t Y_INIT = 10'd110;
    localparam geo_t W_INIT = 10'd110;
    localparam geo_t H_INIT = 10'd110;

    localparam logic [23:0] REP_DLY_DEF = 24'd6250000;
    localparam logic [23:0] REP_PER_DEF = 24'd1250000;

    // One extra bit on the sum so v+STEP can never wrap before the compare.
    function automatic geo_t inc_clamp(input geo_t v, input geo_t lim);
        logic [GEO_W:0] t;
        t = {1'b0, v} + {1'b0, STEP};
        return (t > {1'b0, lim}) ? lim : t[GEO_W-1:0];
    endfunction

    function automatic geo_t dec_floor(input geo_t v, input geo_t floor_v);
        return ({1'b0, v} >= ({1'b0, floor_v} + {1'b0, STEP})) ? (v - STEP) : floor_v;
    endfunction

endpackage

// File: rtl/roi_box_ctrl_key_strobe.sv
// Key level to one-cycle action strobe; rising-edge detect plus an optional
// hold-to-repeat down-counter when ROI_AUTO_REPEAT_EN is defined.
module key_strobe
`ifdef ROI_AUTO_REPEAT_EN
    #(
        parameter logic [23:0] REP_DLY = roi_pkg::REP_DLY_DEF,
        parameter logic [23:0] REP_PER = roi_pkg::REP_PER_DEF
    )
`endif
(
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic strobe
);

    logic level_q;
    logic rise;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) level_q <= 1'b0;
        else     level_q <= level;
    end

    assign rise = level & ~level_q;

`ifdef ROI_AUTO_REPEAT_EN
    logic [23:0] rep_cnt;

    // Terminal count of zero while held marks a repeat; the press itself reloads the delay.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 rep_cnt <= '0;
        else if (!level)         rep_cnt <= '0;
        else if (rise)           rep_cnt <= REP_DLY - 24'd1;
        else if (rep_cnt == '0)  rep_cnt <= REP_PER - 24'd1;
        else                     rep_cnt <= rep_cnt - 24'd1;
    end

    assign strobe = rise | (level & level_q & (rep_cnt == '0));
`else
    assign strobe = rise;
`endif

endmodule

// File: rtl/roi_box_ctrl.sv
// ROI rectangle controller: mode FSM, clamped shadow geometry and frame-start commit.
// Optional hold-to-repeat on the arrow keys is enabled by ROI_AUTO_REPEAT_EN.
module roi_box_ctrl
    import roi_pkg::*;
`ifdef ROI_AUTO_REPEAT_EN
    #(
        parameter logic [23:0] REP_DLY = REP_DLY_DEF,
        parameter logic [23:0] REP_PER = REP_PER_DEF
    )
`endif
(
    input  logic             vga_clk,
    input  logic             sys_rst,
    input  logic             frame_start,
    input  logic             key_up,
    input  logic             key_dn,
    input  logic             key_lt,
    input  logic             key_rt,
    input  logic             key_mode,
    output logic [GEO_W-1:0] x,
    output logic [GEO_W-1:0] y,
    output logic [GEO_W-1:0] w,
    output logic [GEO_W-1:0] h,
    output logic [1:0]       mode,
    output logic             pending
);

    logic [3:0] key_lvl;
    logic [3:0] key_stb;
    logic       act_up, act_dn, act_lt, act_rt;

    mode_e state;
    geo_t  sx, sy, sw, sh;
    geo_t  sx_n, sy_n, sw_n, sh_n;

    assign key_lvl = {key_up, key_dn, key_lt, key_rt};

    for (genvar i = 0; i < 4; i++) begin : g_key
        key_strobe
`ifdef ROI_AUTO_REPEAT_EN
            #(.REP_DLY(REP_DLY), .REP_PER(REP_PER))
`endif
            u_key (
                .clk    (vga_clk),
                .rst    (sys_rst),
                .level  (key_lvl[i]),
                .strobe (key_stb[i])
            );
    end

    // Opposing strobes on one axis cancel; the other axis is unaffected.
    assign act_up = key_stb[3] & ~key_stb[2];
    assign act_dn = key_stb[2] & ~key_stb[3];
    assign act_lt = key_stb[1] & ~key_stb[0];
    assign act_rt = key_stb[0] & ~key_stb[1];

    always_comb begin
        sx_n = sx;
        sy_n = sy;
        sw_n = sw;
        sh_n = sh;
        case (state)
            MODE_MOVE: begin
                if (act_lt)      sx_n = dec_floor(sx, '0);
                else if (act_rt) sx_n = inc_clamp(sx, H_LIM - sw);
                if (act_up)      sy_n = dec_floor(sy, '0);
                else if (act_dn) sy_n = inc_clamp(sy, V_LIM - sh);
            end
            MODE_SIZE: begin
                if (act_rt)      sw_n = inc_clamp(sw, H_LIM - sx);
                else if (act_lt) sw_n = dec_floor(sw, W_MIN);
                if (act_dn)      sh_n = inc_clamp(sh, V_LIM - sy);
                else if (act_up) sh_n = dec_floor(sh, H_MIN);
            end
            default: ;
        endcase
    end

    // Commit reads the registered shadow and mode, so a coincident edit or
    // mode change lands only at the following frame start.
    always_ff @(posedge vga_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state   <= MODE_OFF;
            sx      <= X_INIT;
            sy      <= Y_INIT;
            sw      <= W_INIT;
            sh      <= H_INIT;
            x       <= '0;
            y       <= '0;
            w       <= '0;
            h       <= '0;
            pending <= 1'b0;
        end else begin
            if (key_mode) begin
                case (state)
                    MODE_OFF:  state <= MODE_MOVE;
                    MODE_MOVE: state <= MODE_SIZE;
                    default:   state <= MODE_OFF;
                endcase
            end
            sx <= sx_n;
            sy <= sy_n;
            sw <= sw_n;
            sh <= sh_n;
            if (frame_start) begin
                if (state == MODE_OFF) begin
                    x <= '0;
                    y <= '0;
                    w <= '0;
                    h <= '0;
                end else begin
                    x <= sx;
                    y <= sy;
                    w <= sw;
                    h <= sh;
                end
            end
            pending <= (state != MODE_OFF) && ({sx, sy, sw, sh} != {x, y, w, h});
        end
    end

    assign mode = state;

endmodule

// File: tb/tb_roi_box_ctrl.sv
// Directed bench for roi_box_ctrl (default build): hand-computed geometry after
// key presses, clamps, commit timing, mode cycling and asynchronous reset.
module tb_roi_box_ctrl;

    logic       vga_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       frame_start = 1'b0;
    logic       key_up = 1'b0, key_dn = 1'b0, key_lt = 1'b0, key_rt = 1'b0;
    logic       key_mode = 1'b0;
    logic [9:0] x, y, w, h;
    logic [1:0] mode;
    logic       pending;

    int n_chk  = 0;
    int n_fail = 0;

    roi_box_ctrl dut (
        .vga_clk     (vga_clk),
        .sys_rst     (sys_rst),
        .frame_start (frame_start),
        .key_up      (key_up),
        .key_dn      (key_dn),
        .key_lt      (key_lt),
        .key_rt      (key_rt),
        .key_mode    (key_mode),
        .x           (x),
        .y           (y),
        .w           (w),
        .h           (h),
        .mode        (mode),
        .pending     (pending)
    );

    always #5 vga_clk = ~vga_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge vga_clk);
        #1;
    endtask

    // k = {up, dn, lt, rt}; each press is one cycle high, one cycle low
    task automatic press(input logic [3:0] k, input int n);
        for (int i = 0; i < n; i++) begin
            {key_up, key_dn, key_lt, key_rt} = k;
            tick();
            {key_up, key_dn, key_lt, key_rt} = 4'b0000;
            tick();
        end
    endtask

    task automatic frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic mode_pulse();
        key_mode = 1'b1;
        tick();
        key_mode = 1'b0;
    endtask

    task automatic chk_geo(input string tag, input int ex, input int ey, input int ew, input int eh);
        chk({tag, ".x"}, 32'(x), 32'(ex));
        chk({tag, ".y"}, 32'(y), 32'(ey));
        chk({tag, ".w"}, 32'(w), 32'(ew));
        chk({tag, ".h"}, 32'(h), 32'(eh));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        tick();
        chk_geo("reset", 0, 0, 0, 0);
        chk("reset.mode", 32'(mode), 0);
        chk("reset.pending", 32'(pending), 0);
        #2 sys_rst = 1'b0;
        tick();

        mode_pulse();
        chk("mode_move", 32'(mode), 1);
        tick();
        chk("pend_after_mode", 32'(pending), 1);
        frame();
        chk_geo("first_commit", 110, 110, 110, 110);
        tick();
        chk("pend_clear", 32'(pending), 0);

        press(4'b0010, 10);
        frame();
        chk("lt10.x", 32'(x), 70);
        press(4'b0010, 20);
        frame();
        chk_geo("lt30", 0, 110, 110, 110);

        key_rt = 1'b1;
        frame_start = 1'b1;
        tick();
        key_rt = 1'b0;
        frame_start = 1'b0;
        chk("coinc.x", 32'(x), 0);
        tick();
        chk("coinc.pending", 32'(pending), 1);
        frame();
        chk("coinc_next.x", 32'(x), 4);

        press(4'b1101, 1);
        frame();
        chk_geo("opposing", 8, 110, 110, 110);
        press(4'b1000, 1);
        frame();
        chk("up.y", 32'(y), 106);

        mode_pulse();
        chk("mode_size", 32'(mode), 2);
        press(4'b0001, 230);
        frame();
        chk_geo("w_max", 8, 106, 1015, 110);
        press(4'b0100, 200);
        frame();
        chk("h_max", 32'(h), 613);
        press(4'b0010, 300);
        press(4'b1000, 200);
        frame();
        chk_geo("wh_min", 8, 106, 8, 8);

        press(4'b0001, 1);
        key_mode = 1'b1;
        frame_start = 1'b1;
        tick();
        key_mode = 1'b0;
        frame_start = 1'b0;
        chk("mode_coinc.w", 32'(w), 12);
        chk("mode_coinc.mode", 32'(mode), 0);
        tick();
        chk("off.pending", 32'(pending), 0);
        frame();
        chk_geo("off_commit", 0, 0, 0, 0);

        press(4'b0001, 3);
        mode_pulse();
        frame();
        chk_geo("off_retain", 8, 106, 12, 8);

        tick();
        #2 sys_rst = 1'b1;
        #1;
        chk_geo("async_rst", 0, 0, 0, 0);
        chk("async_rst.mode", 32'(mode), 0);
        chk("async_rst.pending", 32'(pending), 0);
        #1 sys_rst = 1'b0;
        tick();
        mode_pulse();
        frame();
        chk_geo("post_rst", 110, 110, 110, 110);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
